// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, default timing and width helper
// for the button conditioner slice.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_N_BTN      = 6;
  localparam int unsigned DEF_TICK_DIV   = 12000;
  localparam int unsigned DEF_DB_TICKS   = 20;
  localparam int unsigned DEF_RPT_DELAY  = 500;
  localparam int unsigned DEF_RPT_PERIOD = 100;

  // bits needed to hold 0..maxv
  function automatic int unsigned cw(input int unsigned maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button's debounce FSM and auto-repeat timer.
// Ports: clk, rst (async low), s (pressed-high), tick -> level/press/rel/rpt.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_TICKS   = DEF_DB_TICKS,
  parameter int unsigned RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit          RPT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int unsigned DW = cw(DB_TICKS);
  localparam int unsigned RW = cw(RPT_DELAY);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD =
    (RPT_PERIOD >= RPT_DELAY) ? '0 : RW'(RPT_DELAY - RPT_PERIOD);

  btn_state_e state, state_d;
  logic [DW-1:0] db_cnt, db_cnt_d;
  logic [RW-1:0] rpt_cnt, rpt_cnt_d;
  logic level_d, press_d, rel_d, rpt_d;
  logic db_done, rpt_step, rpt_hit;

  assign db_done = tick && (db_cnt == DB_LAST);

  // repeat timer runs only while accepted-pressed and s is high;
  // a glitch into RELEASE_WAIT freezes it
  assign rpt_step = RPT_EN && tick && s &&
                    (state == HELD || state == RELEASE_WAIT);
  assign rpt_hit  = rpt_step && (rpt_cnt == RPT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      db_cnt  <= '0;
      rpt_cnt <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      rpt     <= 1'b0;
    end else begin
      state   <= state_d;
      db_cnt  <= db_cnt_d;
      rpt_cnt <= rpt_cnt_d;
      level   <= level_d;
      press   <= press_d;
      rel     <= rel_d;
      rpt     <= rpt_d;
    end
  end

  always_comb begin
    state_d   = state;
    db_cnt_d  = db_cnt;
    rpt_cnt_d = rpt_cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (db_done) begin
          state_d   = HELD;
          rpt_cnt_d = '0;
        end else if (tick) begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
        end else if (db_done) begin
          state_d = IDLE;
        end else if (tick) begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rpt_step) begin
      rpt_cnt_d = rpt_hit ? RPT_RELOAD : rpt_cnt + 1'b1;
    end
  end

  always_comb begin
    press_d = (state == PRESS_WAIT) && s && db_done;
    rel_d   = (state == RELEASE_WAIT) && !s && db_done;
    rpt_d   = rpt_hit;
    level_d = level;
    if (press_d) level_d = 1'b1;
    if (rel_d)   level_d = 1'b0;
  end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizers, shared 1 ms prescaler, N_BTN channels.
// Ports: clk, rst (async low), btn_raw -> btn_level/press/release/repeat.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned          N_BTN      = DEF_N_BTN,
  parameter int unsigned          TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned          DB_TICKS   = DEF_DB_TICKS,
  parameter int unsigned          RPT_DELAY  = DEF_RPT_DELAY,
  parameter int unsigned          RPT_PERIOD = DEF_RPT_PERIOD,
  parameter bit                   ACTIVE_LOW = 1'b1,
  parameter logic [N_BTN-1:0]     RPT_MASK   = N_BTN'(6'b000011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned PW = cw(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  // raw level of a released button
  localparam logic [N_BTN-1:0] IDLE_LVL = {N_BTN{ACTIVE_LOW}};

  logic [N_BTN-1:0] sync1, sync2, s;
  logic [PW-1:0] pre_cnt;
  logic tick;

  assign tick = (pre_cnt == PRE_LAST);
  assign s    = sync2 ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= IDLE_LVL;
      sync2   <= IDLE_LVL;
      pre_cnt <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_channel #(
      .DB_TICKS  (DB_TICKS),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (RPT_MASK[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .s    (s[i]),
      .tick (tick),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .rpt  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed + random stimulus, reference model
// feeding an event scoreboard checked by an independent monitor.
module tb_btn_conditioner;

  localparam int N  = 6;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RP = 2;
  localparam logic [N-1:0] MASK = 6'b000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level, btn_press;
  logic [N-1:0] btn_release, btn_repeat;

  btn_conditioner #(
    .N_BTN     (N),
    .TICK_DIV  (TD),
    .DB_TICKS  (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP),
    .ACTIVE_LOW(1'b1),
    .RPT_MASK  (MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           stamp;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic [N-1:0] level;
  } ev_t;

  ev_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a channel flips its accepted level after DB ticks
  // of s continuously differing from it (the first differing cycle
  // only arms the count); held time is counted in ticks.
  logic [N-1:0] m_s1 = '1;
  logic [N-1:0] m_s2 = '1;
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] m_mask = MASK;
  int m_pre = 0;
  int m_run[N];
  bit m_arm[N];
  int m_hold[N];

  always @(posedge clk) begin : model
    logic [N-1:0] sv, pr, rl, rp;
    bit tk;
    ev_t e;
    if (!rst) begin
      m_s1 = '1;
      m_s2 = '1;
      m_lvl = '0;
      m_pre = 0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0;
        m_arm[c] = 1'b0;
        m_hold[c] = 0;
      end
    end else begin
      sv = ~m_s2;
      tk = (m_pre == TD - 1);
      pr = '0;
      rl = '0;
      rp = '0;
      for (int c = 0; c < N; c++) begin
        if (m_lvl[c] && sv[c] && tk && m_mask[c]) begin
          m_hold[c]++;
          if (m_hold[c] >= RD && (m_hold[c] - RD) % RP == 0)
            rp[c] = 1'b1;
        end
        if (sv[c] == m_lvl[c]) begin
          m_arm[c] = 1'b0;
          m_run[c] = 0;
        end else if (!m_arm[c]) begin
          m_arm[c] = 1'b1;
        end else if (tk) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            if (m_lvl[c]) rl[c] = 1'b1;
            else begin
              pr[c] = 1'b1;
              m_hold[c] = 0;
            end
            m_lvl[c] = ~m_lvl[c];
            m_arm[c] = 1'b0;
            m_run[c] = 0;
          end
        end
      end
      if ((pr | rl | rp) != '0) begin
        e.stamp = cyc + 1;
        e.press = pr;
        e.rel = rl;
        e.rpt = rp;
        e.level = m_lvl;
        q.push_back(e);
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      m_pre = tk ? 0 : m_pre + 1;
    end
  end

  logic [N-1:0] exp_lvl = '0;

  always @(negedge clk) begin : monitor
    logic [N-1:0] ep, er, et, el;
    ev_t ev;
    ep = '0;
    er = '0;
    et = '0;
    if (!rst) begin
      exp_lvl = '0;
    end else begin
      while (q.size() > 0 && q[0].stamp < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_event stamp=%0d now=%0d",
                 q[0].stamp, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].stamp == cyc) begin
        ev = q.pop_front();
        ep = ev.press;
        er = ev.rel;
        et = ev.rpt;
        exp_lvl = ev.level;
      end
    end
    el = exp_lvl;
    tests++;
    if ({btn_press, btn_release, btn_repeat, btn_level} !==
        {ep, er, et, el}) begin
      fails++;
      $display("FAIL outputs cyc=%0d rst=%b got p=%b r=%b t=%b l=%b exp p=%b r=%b t=%b l=%b",
               cyc, rst, btn_press, btn_release, btn_repeat,
               btn_level, ep, er, et, el);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin : stim
    int ch;
    #1 rst = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);
    // clean press/release on channel 0
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    btn_raw[0] = 1'b1;
    wait_cyc(30);
    // bouncing channel 2
    for (int k = 0; k < 10; k++) begin
      btn_raw[2] = ~btn_raw[2];
      wait_cyc(3);
    end
    btn_raw[2] = 1'b0;
    wait_cyc(30);
    btn_raw[2] = 1'b1;
    wait_cyc(30);
    // auto-repeat on 1, masked channel 5
    btn_raw[1] = 1'b0;
    btn_raw[5] = 1'b0;
    wait_cyc(80);
    btn_raw[1] = 1'b1;
    btn_raw[5] = 1'b1;
    wait_cyc(30);
    // one-tick release glitch on channel 3
    btn_raw[3] = 1'b0;
    wait_cyc(30);
    btn_raw[3] = 1'b1;
    wait_cyc(4);
    btn_raw[3] = 1'b0;
    wait_cyc(30);
    btn_raw[3] = 1'b1;
    wait_cyc(30);
    // reset while channel 0 is held
    btn_raw[0] = 1'b0;
    wait_cyc(30);
    rst = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(40);
    btn_raw[0] = 1'b1;
    wait_cyc(30);
    // simultaneous press on 0 and 1
    btn_raw[1:0] = 2'b00;
    wait_cyc(30);
    btn_raw[1:0] = 2'b11;
    wait_cyc(30);
    // random bursts with occasional reset
    for (int i = 0; i < 300; i++) begin
      ch = $urandom_range(0, N - 1);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b0;
        wait_cyc($urandom_range(1, 3));
        rst = 1'b1;
      end else begin
        btn_raw[ch] = ~btn_raw[ch];
      end
      wait_cyc($urandom_range(1, 14));
    end
    btn_raw = '1;
    wait_cyc(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
